// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: each channel divides CLK by a latched
// ratio and bypasses CLK while idle or when the requested ratio is below 2.
module clk_div_multi #(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_CH-1:0]       i_en,
    input  logic [NUM_CH*WIDTH-1:0] i_ratio,
    output logic [NUM_CH-1:0]       o_div_clk,
    output logic [NUM_CH-1:0]       o_tick,
    output logic [NUM_CH-1:0]       o_upd,
    output logic [NUM_CH-1:0]       o_run
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t           state_q, state_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic [WIDTH-1:0] ratio_q, ratio_d;
        logic             out_q, out_d;
        logic             tick_q, tick_d;
        logic             upd_q, upd_d;
        logic [WIDTH-1:0] ratio_in;
        logic [WIDTH-1:0] half;
        logic             go;
        logic             wrap;
        logic             run_c;
        logic             div_c;

        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                ratio_q <= '0;
                out_q   <= 1'b0;
                tick_q  <= 1'b0;
                upd_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                ratio_q <= ratio_d;
                out_q   <= out_d;
                tick_q  <= tick_d;
                upd_q   <= upd_d;
            end
        end

        always_comb begin
            ratio_in = i_ratio[g*WIDTH +: WIDTH];
            go       = i_en[g] && (ratio_in >= WIDTH'(2));
            // ceil(ratio/2) without widening: ratio_q >> 1 plus the dropped LSB
            half     = (ratio_q >> 1) + WIDTH'(ratio_q[0]);
            wrap     = (cnt_q == ratio_q - WIDTH'(1));

            state_d = state_q;
            cnt_d   = cnt_q;
            ratio_d = ratio_q;
            out_d   = out_q;
            tick_d  = 1'b0;
            upd_d   = 1'b0;

            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    out_d = 1'b0;
                    if (go) begin
                        state_d = RUN;
                        ratio_d = ratio_in;
                        tick_d  = 1'b1;
                        upd_d   = 1'b1;
                    end
                end
                RUN: begin
                    if (wrap) begin
                        cnt_d  = '0;
                        out_d  = 1'b0;
                        tick_d = 1'b1;
                        if (go) begin
                            ratio_d = ratio_in;
                            upd_d   = (ratio_in != ratio_q);
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                        out_d = (cnt_d >= half);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_comb begin
            run_c = (state_q == RUN);
            div_c = run_c ? out_q : CLK;
        end

        assign o_run[g]     = run_c;
        assign o_div_clk[g] = div_c;
        assign o_tick[g]    = tick_q;
        assign o_upd[g]     = upd_q;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: a period-position model predicts each
// channel's registered outputs per edge; predictions are queued and popped after the edge.
module tb_clk_div_multi;

    localparam int NC = 2;
    localparam int W  = 8;

    logic            CLK;
    logic            RST;
    logic [NC-1:0]   i_en;
    logic [NC*W-1:0] i_ratio;
    logic [NC-1:0]   o_div_clk;
    logic [NC-1:0]   o_tick;
    logic [NC-1:0]   o_upd;
    logic [NC-1:0]   o_run;

    typedef logic [4*NC-1:0] vec_t;
    vec_t sb[$];

    int total = 0;
    int bad   = 0;

    int m_run[NC];
    int m_pos[NC];
    int m_n[NC];

    clk_div_multi #(.NUM_CH(NC), .WIDTH(W)) dut (
        .CLK(CLK),
        .RST(RST),
        .i_en(i_en),
        .i_ratio(i_ratio),
        .o_div_clk(o_div_clk),
        .o_tick(o_tick),
        .o_upd(o_upd),
        .o_run(o_run)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_run[c] = 0;
            m_pos[c] = 0;
            m_n[c]   = 0;
        end
    endtask

    // Drive inputs, predict the post-edge outputs, queue them, advance to edge+1.
    task automatic drive_cycle(input logic [1:0] en, input int r0, input int r1);
        logic [NC-1:0] er, ed, et, eu;
        int r;
        logic go;
        i_en    = en;
        i_ratio = {W'(r1), W'(r0)};
        for (int c = 0; c < NC; c++) begin
            r     = (c == 0) ? r0 : r1;
            go    = en[c] && (r >= 2);
            et[c] = 1'b0;
            eu[c] = 1'b0;
            if (m_run[c] == 0) begin
                if (go) begin
                    m_run[c] = 1;
                    m_n[c]   = r;
                    m_pos[c] = 0;
                    et[c]    = 1'b1;
                    eu[c]    = 1'b1;
                end
            end else if (m_pos[c] == m_n[c] - 1) begin
                et[c]    = 1'b1;
                m_pos[c] = 0;
                if (go) begin
                    eu[c]  = (r != m_n[c]);
                    m_n[c] = r;
                end else begin
                    m_run[c] = 0;
                end
            end else begin
                m_pos[c]++;
            end
            er[c] = (m_run[c] != 0);
            ed[c] = er[c] ? (m_pos[c] >= (m_n[c] + 1) / 2) : 1'b1;
        end
        sb.push_back({er, ed, et, eu});
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST     = 1'b0;
        i_en    = '0;
        i_ratio = '0;
        model_reset();
        #12;
        total++;
        if ({o_run, o_tick, o_upd} !== 6'b0 || o_div_clk !== {NC{CLK}}) begin
            bad++;
            $display("FAIL reset_hi got run=%b tick=%b upd=%b div=%b exp 0/0/0 div=clk", o_run, o_tick, o_upd, o_div_clk);
        end
        @(negedge CLK);
        #1;
        total++;
        if (o_div_clk !== 2'b00) begin
            bad++;
            $display("FAIL reset_bypass_lo got div=%b exp 00", o_div_clk);
        end
        RST = 1'b1;
    endtask

    task automatic test_basic();
        vec_t exp_v, got_v;
        int t0 = 0, t1 = 0, u1 = 0;
        for (int k = 0; k < 40; k++) begin
            drive_cycle(2'b11, 4, 5);
            got_v = {o_run, o_div_clk, o_tick, o_upd};
            exp_v = sb.pop_front();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL basic cyc=%0d got=%b exp=%b", k, got_v, exp_v);
            end
            t0 += int'(o_tick[0]);
            t1 += int'(o_tick[1]);
            u1 += int'(o_upd[1]);
        end
        total++;
        if (t0 !== 10) begin bad++; $display("FAIL basic_ticks0 got=%0d exp=10", t0); end
        total++;
        if (t1 !== 8) begin bad++; $display("FAIL basic_ticks1 got=%0d exp=8", t1); end
        total++;
        if (u1 !== 1) begin bad++; $display("FAIL basic_upd1 got=%0d exp=1", u1); end
    endtask

    task automatic test_change_ratio();
        vec_t exp_v, got_v;
        int u0 = 0;
        for (int k = 0; k < 8 && m_pos[0] != 1; k++) begin
            drive_cycle(2'b11, 4, 5);
            got_v = {o_run, o_div_clk, o_tick, o_upd};
            exp_v = sb.pop_front();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL chg_align cyc=%0d got=%b exp=%b", k, got_v, exp_v);
            end
        end
        for (int k = 0; k < 24; k++) begin
            drive_cycle(2'b11, 6, 5);
            got_v = {o_run, o_div_clk, o_tick, o_upd};
            exp_v = sb.pop_front();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL chg cyc=%0d got=%b exp=%b", k, got_v, exp_v);
            end
            u0 += int'(o_upd[0]);
        end
        total++;
        if (u0 !== 1) begin bad++; $display("FAIL chg_upd0 got=%0d exp=1", u0); end
    endtask

    task automatic test_disable();
        vec_t exp_v, got_v;
        for (int k = 0; k < 12; k++) begin
            drive_cycle(2'b10, 6, 1);
            got_v = {o_run, o_div_clk, o_tick, o_upd};
            exp_v = sb.pop_front();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL dis cyc=%0d got=%b exp=%b", k, got_v, exp_v);
            end
        end
        @(negedge CLK);
        #1;
        total++;
        if (o_run !== 2'b00 || o_div_clk !== 2'b00) begin
            bad++;
            $display("FAIL dis_bypass got run=%b div=%b exp 00/00", o_run, o_div_clk);
        end
    endtask

    task automatic test_async_reset();
        vec_t exp_v, got_v;
        for (int k = 0; k < 10 && !(m_run[0] != 0 && m_pos[0] >= 2); k++) begin
            drive_cycle(2'b11, 4, 5);
            got_v = {o_run, o_div_clk, o_tick, o_upd};
            exp_v = sb.pop_front();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL ar_pre cyc=%0d got=%b exp=%b", k, got_v, exp_v);
            end
        end
        total++;
        if (o_div_clk[0] !== 1'b1) begin
            bad++;
            $display("FAIL ar_highphase got=%b exp=1", o_div_clk[0]);
        end
        #1 RST = 1'b0;
        #1;
        total++;
        if ({o_run, o_tick, o_upd} !== 6'b0 || o_div_clk !== 2'b11) begin
            bad++;
            $display("FAIL ar_async got run=%b tick=%b upd=%b div=%b exp 0/0/0/11", o_run, o_tick, o_upd, o_div_clk);
        end
        @(posedge CLK);
        #1;
        total++;
        if (o_run !== 2'b00 || o_tick !== 2'b00) begin
            bad++;
            $display("FAIL ar_hold got run=%b tick=%b exp 00/00", o_run, o_tick);
        end
        @(negedge CLK);
        RST = 1'b1;
        model_reset();
        for (int k = 0; k < 10; k++) begin
            drive_cycle(2'b11, 4, 5);
            got_v = {o_run, o_div_clk, o_tick, o_upd};
            exp_v = sb.pop_front();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL ar_post cyc=%0d got=%b exp=%b", k, got_v, exp_v);
            end
        end
    endtask

    task automatic test_extremes();
        vec_t exp_v, got_v;
        int hi0 = 0, t1 = 0;
        for (int k = 0; k < 10 && (m_run[0] != 0 || m_run[1] != 0); k++) begin
            drive_cycle(2'b00, 4, 5);
            got_v = {o_run, o_div_clk, o_tick, o_upd};
            exp_v = sb.pop_front();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL ext_drain cyc=%0d got=%b exp=%b", k, got_v, exp_v);
            end
        end
        for (int k = 0; k < 520; k++) begin
            drive_cycle(2'b11, 255, 2);
            got_v = {o_run, o_div_clk, o_tick, o_upd};
            exp_v = sb.pop_front();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL ext cyc=%0d got=%b exp=%b", k, got_v, exp_v);
            end
            if (k < 255) hi0 += int'(o_div_clk[0]);
            t1 += int'(o_tick[1]);
        end
        total++;
        if (hi0 !== 127) begin bad++; $display("FAIL ext_high255 got=%0d exp=127", hi0); end
        total++;
        if (t1 !== 260) begin bad++; $display("FAIL ext_ticks2 got=%0d exp=260", t1); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_change_ratio();
        test_disable();
        test_async_reset();
        test_extremes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
